// File: rtl/led_fader.sv
// led_fader: fades a 16-bit LED pattern in, holds it, and cross-fades to the
// next pattern through black, using a PWM dimmer that ramps one brightness
// level every STEP_DIV clocks.
//
// Ports
//   clk           : clock, all flops on the rising edge
//   rst_n         : asynchronous active-low reset
//   pattern_in    : next LED pattern from the pattern source
//   pattern_valid : pattern_in is valid
//   pattern_ready : registered; high only in IDLE and HOLD
//   flag_led      : registered drive to the board LEDs
module led_fader #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP_DIV = 390
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pattern_in,
  input  logic        pattern_valid,
  output logic        pattern_ready,
  output logic [15:0] flag_led
);

  localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;
  localparam logic [PWM_BITS-1:0] LEVEL_MIN = '0;
  localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_IN  = 2'd1,
    HOLD     = 2'd2,
    FADE_OUT = 2'd3
  } state_t;

  state_t              state;
  logic [15:0]         cur_pattern;
  logic [15:0]         next_pattern;
  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [DIV_W-1:0]    div_cnt;

  logic accept_c;
  logic step_c;
  logic lit_c;

  // Handshake, step strobe and PWM compare, all from registered state.
  assign accept_c = pattern_valid & pattern_ready;
  assign step_c   = (div_cnt == DIV_LAST);
  // Strict compare: level MAX never reaches 100% duty during a fade.
  assign lit_c    = (pwm_cnt < level);

  // Fader state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cur_pattern   <= '0;
      next_pattern  <= '0;
      level         <= '0;
      div_cnt       <= '0;
      pwm_cnt       <= '0;
      flag_led      <= '0;
      pattern_ready <= 1'b1;
    end else begin
      // PWM carrier free-runs regardless of state.
      pwm_cnt <= pwm_cnt + 1'b1;

      case (state)
        IDLE: begin
          flag_led <= '0;
          if (accept_c) begin
            cur_pattern   <= pattern_in;
            level         <= LEVEL_MIN;
            div_cnt       <= '0;
            pattern_ready <= 1'b0;
            state         <= FADE_IN;
          end
        end

        FADE_IN: begin
          flag_led <= lit_c ? cur_pattern : 16'h0000;
          div_cnt  <= step_c ? '0 : div_cnt + 1'b1;
          if (step_c) begin
            // The last step at MAX is spent at MAX, so each fade is (MAX+1) steps.
            if (level == LEVEL_MAX) begin
              pattern_ready <= 1'b1;
              state         <= HOLD;
            end else begin
              level <= level + 1'b1;
            end
          end
        end

        HOLD: begin
          flag_led <= cur_pattern;
          if (accept_c) begin
            // Always cross-fade, even when the new pattern matches the old one.
            next_pattern  <= pattern_in;
            level         <= LEVEL_MAX;
            div_cnt       <= '0;
            pattern_ready <= 1'b0;
            state         <= FADE_OUT;
          end
        end

        FADE_OUT: begin
          flag_led <= lit_c ? cur_pattern : 16'h0000;
          div_cnt  <= step_c ? '0 : div_cnt + 1'b1;
          if (step_c) begin
            if (level == LEVEL_MIN) begin
              cur_pattern <= next_pattern;
              state       <= FADE_IN;
            end else begin
              level <= level - 1'b1;
            end
          end
        end

        default: begin
          flag_led      <= '0;
          pattern_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed scoreboard bench for led_fader (PWM_BITS=2, STEP_DIV=2).
// The driver pushes one expected fade per accepted pattern; the monitor
// follows each pattern_ready low window and checks every LED sample in it.
`timescale 1ns/1ps
module tb_led_fader;

  localparam int unsigned PWM_BITS  = 2;
  localparam int unsigned STEP_DIV  = 2;
  localparam int unsigned MAXV      = 3;
  localparam int unsigned FADE_CLKS = (MAXV + 1) * STEP_DIV;

  typedef struct {
    int unsigned split;    // samples belonging to the fade-out part
    int unsigned low_len;  // clocks with pattern_ready low
    logic [15:0] pat_a;    // pattern shown before the accept
    logic [15:0] pat_b;    // pattern being faded in
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pattern_in = 16'h0000;
  logic        pattern_valid = 1'b0;
  logic        pattern_ready;
  logic [15:0] flag_led;

  int vectors = 0;
  int miscompares = 0;

  exp_t        q[$];
  exp_t        cur;
  bit          in_win = 1'b0;
  bit          final_pend = 1'b0;
  bit          prev_ready = 1'b1;
  int unsigned m = 0;
  int unsigned a_cyc = 0;
  int unsigned cyc = 0;
  logic [15:0] fin_pat = 16'h0000;
  int unsigned lvl = 0;
  int unsigned pwm = 0;
  logic [15:0] pat = 16'h0000;

  logic [15:0] shown = 16'h0000;
  bit          in_hold = 1'b0;

  led_fader #(.PWM_BITS(PWM_BITS), .STEP_DIV(STEP_DIV)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pattern_in    (pattern_in),
    .pattern_valid (pattern_valid),
    .pattern_ready (pattern_ready),
    .flag_led      (flag_led)
  );

  always #5 clk = ~clk;

  // Clocks since reset release; matches the free-running PWM phase.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Monitor: one window per accepted pattern, exact LED value each clock.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_win     = 1'b0;
      final_pend = 1'b0;
      prev_ready = 1'b1;
    end else begin
      if (final_pend) begin
        check("hold_led", flag_led, fin_pat);
        final_pend = 1'b0;
      end
      if (in_win) begin
        m++;
        if (m <= cur.split) begin
          lvl = MAXV - (m - 1) / STEP_DIV;
          pat = cur.pat_a;
        end else begin
          lvl = (m - cur.split - 1) / STEP_DIV;
          pat = cur.pat_b;
        end
        pwm = (a_cyc + m - 1) % (MAXV + 1);
        check("fade_led", flag_led, (pwm < lvl) ? pat : 16'h0000);
        check("fade_ready", {15'b0, pattern_ready}, (m == cur.low_len) ? 16'h0001 : 16'h0000);
        if (m >= cur.low_len || pattern_ready) begin
          in_win     = 1'b0;
          final_pend = 1'b1;
          fin_pat    = cur.pat_b;
        end
      end else if (prev_ready && !pattern_ready) begin
        if (q.size() == 0) begin
          fail_now("unexpected_accept");
        end else begin
          cur    = q.pop_front();
          a_cyc  = cyc;
          m      = 0;
          in_win = 1'b1;
          check("accept_led", flag_led, cur.pat_a);
        end
      end
      prev_ready = pattern_ready;
    end
  end

  // Offer a pattern until accepted; keep=1 leaves pattern_valid high afterwards.
  task automatic send(input logic [15:0] p, input bit keep);
    exp_t        e;
    int unsigned n = 0;
    @(negedge clk);
    pattern_in    = p;
    pattern_valid = 1'b1;
    while (!pattern_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!pattern_ready) begin
      fail_now("accept_timeout");
    end else begin
      e.split   = in_hold ? FADE_CLKS : 0;
      e.low_len = e.split + FADE_CLKS;
      e.pat_a   = shown;
      e.pat_b   = p;
      q.push_back(e);
      shown   = p;
      in_hold = 1'b1;
      @(posedge clk);
      #1;
      if (!keep) pattern_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((q.size() != 0 || in_win || final_pend) && n < 200);
    if (n >= 200) fail_now("drain_timeout");
  endtask

  task automatic steady(input int unsigned cycles);
    for (int i = 0; i < int'(cycles); i++) begin
      @(negedge clk);
      check("steady_led", flag_led, shown);
      check("steady_ready", {15'b0, pattern_ready}, 16'h0001);
    end
  endtask

  initial begin
    // Reset with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pattern_in    = 16'($urandom);
      pattern_valid = 1'($urandom_range(0, 1));
      #1;
      check("reset_led", flag_led, 16'h0000);
      check("reset_ready", {15'b0, pattern_ready}, 16'h0001);
    end
    @(negedge clk);
    pattern_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_led", flag_led, 16'h0000);
      check("idle_ready", {15'b0, pattern_ready}, 16'h0001);
    end

    // Fade in from IDLE, then hold.
    send(16'hAE20, 1'b0);
    drain();
    steady(3);

    // Cross-fade HOLD -> HOLD.
    send(16'h00FF, 1'b0);
    drain();
    steady(3);

    // Producer holds valid through a fade; accepted at the first ready edge.
    send(16'h5A5A, 1'b1);
    send(16'h1234, 1'b0);
    drain();
    steady(2);

    // Same pattern again still takes the full cross-fade.
    send(16'h1234, 1'b0);
    drain();
    steady(2);

    // Abort mid FADE_OUT with an asynchronous reset pulse.
    send(16'hC3C3, 1'b0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_led", flag_led, 16'h0000);
    check("abort_ready", {15'b0, pattern_ready}, 16'h0001);
    q.delete();
    in_hold = 1'b0;
    shown   = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_abort_led", flag_led, 16'h0000);
    send(16'hAE20, 1'b0);
    drain();
    steady(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

endmodule
